// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 set-2 make/break/E0 byte streams from the ps2_keyboard FIFO into key state and a BCD press count.
// Latency: outputs update on the edge ending POP, two cycles after ready is sampled in IDLE; one byte per 2+POP_GAP cycles.
// Backpressure: pops only when ready=1 in IDLE, one nextdata_n low cycle per byte; ascii output enabled by PS2_DECODER_ASCII_EN.
module ps2_key_decoder #(
  parameter int unsigned POP_GAP      = 1,
  parameter int unsigned COUNT_REPEAT = 0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_down,
  output logic       key_event,
  output logic [7:0] count_bcd,
  output logic       err
`ifdef PS2_DECODER_ASCII_EN
  , output logic [7:0] ascii
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_GAP} state_t;

  localparam logic [2:0] GAP_LAST = 3'(POP_GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] gap_cnt_q, gap_cnt_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_down_q, key_down_d;
  logic       key_event_q, key_event_d;
  logic [7:0] count_q, count_d;
  logic       err_q, err_d;
  logic       brk_pend_q, brk_pend_d;
  logic       ext_pend_q, ext_pend_d;
  logic       count_make;
  logic       same_key;
`ifdef PS2_DECODER_ASCII_EN
  logic [7:0] ascii_q, ascii_d;
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

`ifdef PS2_DECODER_ASCII_EN
  function automatic logic [7:0] ascii_of(input logic [7:0] sc);
    case (sc)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
      8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
      8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
      8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
      8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      default: return 8'h00;
    endcase
  endfunction
`endif

  // Pop handshake sequencing and scan-code decode; every output is taken from a flop.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    gap_cnt_d    = gap_cnt_q;
    nextdata_n_d = nextdata_n_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_down_d   = key_down_q;
    key_event_d  = 1'b0;
    count_d      = count_q;
    err_d        = err_q | overflow;
    brk_pend_d   = brk_pend_q;
    ext_pend_d   = ext_pend_q;
    count_make   = 1'b0;
    same_key     = (byte_q == key_code_q) && (ext_pend_q == key_ext_q);
`ifdef PS2_DECODER_ASCII_EN
    ascii_d      = ascii_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          byte_d       = data;
          nextdata_n_d = 1'b0;
          state_d      = ST_POP;
        end
      end
      ST_POP: begin
        nextdata_n_d = 1'b1;
        gap_cnt_d    = '0;
        state_d      = ST_GAP;
        if (byte_q == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else if (brk_pend_q) begin
          // Release only counts when it names the held key including its E0 flavour.
          if (same_key) key_down_d = 1'b0;
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end else begin
          if (key_down_q && same_key) begin
            // Typematic repeat of the held key.
            count_make = (COUNT_REPEAT != 0);
          end else begin
            key_code_d = byte_q;
            key_ext_d  = ext_pend_q;
            key_down_d = 1'b1;
            count_make = 1'b1;
`ifdef PS2_DECODER_ASCII_EN
            ascii_d    = ext_pend_q ? 8'h00 : ascii_of(byte_q);
`endif
          end
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end
        if (count_make) begin
          key_event_d = 1'b1;
          count_d     = bcd_inc(count_q);
        end
      end
      ST_GAP: begin
        // Let the keyboard FIFO settle its head/ready after the pop.
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any pending prefix.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      byte_q       <= 8'h00;
      gap_cnt_q    <= 3'd0;
      nextdata_n_q <= 1'b1;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_down_q   <= 1'b0;
      key_event_q  <= 1'b0;
      count_q      <= 8'h00;
      err_q        <= 1'b0;
      brk_pend_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
`ifdef PS2_DECODER_ASCII_EN
      ascii_q      <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      gap_cnt_q    <= gap_cnt_d;
      nextdata_n_q <= nextdata_n_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_down_q   <= key_down_d;
      key_event_q  <= key_event_d;
      count_q      <= count_d;
      err_q        <= err_d;
      brk_pend_q   <= brk_pend_d;
      ext_pend_q   <= ext_pend_d;
`ifdef PS2_DECODER_ASCII_EN
      ascii_q      <= ascii_d;
`endif
    end
  end

  assign nextdata_n = nextdata_n_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_down   = key_down_q;
  assign key_event  = key_event_q;
  assign count_bcd  = count_q;
  assign err        = err_q;
`ifdef PS2_DECODER_ASCII_EN
  assign ascii      = ascii_q;
`endif

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of ps2_keyboard and consumes its scan-code FIFO through the ready/nextdata_n handshake.
- Decodes PS/2 set-2 make, break (F0) and extended (E0) sequences into the current key state and a BCD press counter.
- Outputs feed bcd7seg digit drivers in top: key_code nibbles and count_bcd nibbles.

Parameters:
- POP_GAP, default 1: idle cycles after each pop before data/ready are sampled again. Range 1..7.
- COUNT_REPEAT, default 0: 1 = typematic auto-repeat makes also increment the counter; 0 = they do not.

Ports:
- clk  input  1  system clock, same clock as ps2_keyboard.
- clrn  input  1  asynchronous active-low reset; also drives ps2_keyboard clrn.
- data  input  8  FIFO head byte from ps2_keyboard.
- ready  input  1  FIFO non-empty from ps2_keyboard.
- overflow  input  1  FIFO overflow flag from ps2_keyboard.
- nextdata_n  output  1  active-low pop strobe to ps2_keyboard.
- key_code  output  8  scan code of the most recently pressed key.
- key_ext  output  1  key_code was E0-prefixed.
- key_down  output  1  key_code currently held.
- key_event  output  1  one-cycle pulse on every counted make.
- count_bcd  output  8  two BCD digits of counted makes, 00..99.
- err  output  1  sticky overflow indicator.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on clrn.
- Reset values: nextdata_n=1; key_code=00, key_ext=0, key_down=0, key_event=0, count_bcd=00, err=0. Internal flags brk_pend=0, ext_pend=0. FSM in IDLE.
- Reset asserted mid-sequence discards any pending E0/F0 prefix.
- FSM states and transitions:
  - IDLE: if ready=1, latch data into byte_r, drive nextdata_n=0 (registered) and go to POP. Otherwise stay.
  - POP: nextdata_n=0 for exactly this one cycle. Decode byte_r. Return nextdata_n to 1 and go to GAP.
  - GAP: wait POP_GAP cycles with nextdata_n=1, then go to IDLE.
- Throughput: one byte per 2+POP_GAP cycles at most. Each byte is popped exactly once.
- Decode, applied in POP:
  - byte E0: ext_pend=1.
  - byte F0: brk_pend=1. Any ext_pend is kept.
  - Other byte b with brk_pend=1 (release):
    - If b==key_code and ext_pend==key_ext, key_down=0.
    - Otherwise the release is ignored.
    - Clear both flags.
  - Other byte b with brk_pend=0 (make):
    - If key_down=1 and b==key_code and ext_pend==key_ext, this is a repeat. Nothing changes unless COUNT_REPEAT=1, in which case it is counted.
    - Otherwise key_code=b, key_ext=ext_pend, key_down=1, and the make is counted.
    - Clear both flags.
  - Duplicate prefixes (E0 E0, F0 F0) are idempotent.
- Counted make:
  - key_event=1 in the cycle after POP, 0 otherwise.
  - count_bcd increments in BCD: low digit 9 rolls to 0 and carries; 99 wraps to 00.
- Outputs are registered and update on the clock edge ending POP.
- err: set when overflow=1 is sampled on any edge. Cleared only by reset. Decoding continues after err is set.
- ready dropping during POP or GAP is harmless; the next sample occurs only in IDLE.

Optional Feature:
- Macro: PS2_DECODER_ASCII_EN.
- Defined:
  - Adds output port ascii [7:0], registered and updated in the same cycle as key_code.
  - Maps set-2 codes for a-z (lowercase) and 0-9 to ASCII, e.g. 1C->61 'a', 32->62 'b', 21->63 'c', 45->30 '0', 16->31 '1'.
  - Unmapped codes and any key_ext=1 key give 00. Reset value is 00.
- Undefined: the ascii port and the lookup logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then feed byte 1C with ready=1 -> exactly one nextdata_n low pulse. key_code=1C, key_down=1, key_event pulses once, count_bcd=01, ascii=61 (if enabled).
- Feed 1C 1C 1C then F0 1C, COUNT_REPEAT=0 -> count_bcd stays 01, single key_event, key_down=0 after the 1C following F0.
- Feed E0 75 then F0 75 -> key_code=75, key_ext=1, count_bcd=01. The non-extended release 75 is ignored and key_down stays 1. Then E0 F0 75 -> key_down=0.
- Make 1C then release F0 32 -> key_down stays 1 and key_code stays 1C.
- 100 alternating makes of 1C and 32 from reset -> count_bcd reads 09->10, 99, then wraps to 00 on the 100th make.
- overflow pulsed for 1 cycle -> err=1 and stays 1 through later traffic. Assert clrn low after E0 is received -> all outputs return to reset values, and a following 75 decodes with key_ext=0.
